axi4_r_burst_arbiter: RTL and testbench

- Shares one slave-side AXI4 R channel among NUM_IN read-response sources, for example the translated-master return path and the RAB error-response generator.
- Arbitration is round-robin at burst granularity. A grant is held from the first beat until the rlast handshake, so beats of different bursts never interleave.
- Sits upstream of the R-channel buffer feeding the slave port.

---
 rtl/axi4_r_burst_arbiter.sv | 177 +++++++++++++++++
 tb/tb_axi4_r_burst_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_r_burst_arbiter.sv
// Burst-granular round-robin arbiter sharing one AXI4 R channel among NUM_IN sources.
// Define AXI4_R_BURST_ARBITER_OUT_REG_EN to register the output through a 2-entry skid buffer.
module axi4_r_burst_arbiter #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 4,
  parameter int NUM_IN         = 2
) (
  input  logic                               axi4_aclk,
  input  logic                               axi4_arstn,
  input  logic [NUM_IN*AXI_ID_WIDTH-1:0]     in_rid,
  input  logic [NUM_IN*2-1:0]                in_rresp,
  input  logic [NUM_IN*AXI_DATA_WIDTH-1:0]   in_rdata,
  input  logic [NUM_IN-1:0]                  in_rlast,
  input  logic [NUM_IN*AXI_USER_WIDTH-1:0]   in_ruser,
  input  logic [NUM_IN-1:0]                  in_rvalid,
  output logic [NUM_IN-1:0]                  in_rready,
  output logic [AXI_ID_WIDTH-1:0]            s_axi4_rid,
  output logic [1:0]                         s_axi4_rresp,
  output logic [AXI_DATA_WIDTH-1:0]          s_axi4_rdata,
  output logic                               s_axi4_rlast,
  output logic [AXI_USER_WIDTH-1:0]          s_axi4_ruser,
  output logic                               s_axi4_rvalid,
  input  logic                               s_axi4_rready,
  output logic                               busy_o
);

  localparam int PTR_W = $clog2(NUM_IN);

  typedef enum logic {IDLE, LOCKED} state_e;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [1:0]                resp;
    logic [AXI_DATA_WIDTH-1:0] data;
    logic                      last;
    logic [AXI_USER_WIDTH-1:0] user;
  } beat_t;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] grant_q, grant_d;
  logic [PTR_W-1:0] scan_sel, sel;
  logic             found;
  beat_t            src_beat [NUM_IN];
  beat_t            arb_beat;
  logic             arb_valid, arb_ready, hs;

  // Compare-and-reset keeps the wrap correct when NUM_IN is not a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_IN - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
    assign src_beat[i] = {in_rid[i*AXI_ID_WIDTH +: AXI_ID_WIDTH],
                          in_rresp[i*2 +: 2],
                          in_rdata[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH],
                          in_rlast[i],
                          in_ruser[i*AXI_USER_WIDTH +: AXI_USER_WIDTH]};
  end

  // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    int idx;
    found    = 1'b0;
    scan_sel = '0;
    idx      = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (!found && in_rvalid[PTR_W'(idx)]) begin
        found    = 1'b1;
        scan_sel = PTR_W'(idx);
      end
    end
  end

  assign sel       = (state_q == LOCKED) ? grant_q : scan_sel;
  assign arb_beat  = src_beat[sel];
  assign arb_valid = (state_q == LOCKED) ? in_rvalid[grant_q] : found;
  assign hs        = arb_valid & arb_ready;
  assign busy_o    = (state_q == LOCKED);

  always_comb begin
    in_rready = '0;
    if (state_q == LOCKED || found) in_rready[sel] = arb_ready;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          if (arb_beat.last) begin
            rr_ptr_d = ptr_inc(sel);
          end else begin
            state_d = LOCKED;
            grant_d = sel;
          end
        end
      end
      LOCKED: begin
        if (hs && arb_beat.last) begin
          state_d  = IDLE;
          rr_ptr_d = ptr_inc(grant_q);
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

`ifdef AXI4_R_BURST_ARBITER_OUT_REG_EN
  beat_t out_q, skid_q;
  logic  out_valid_q, skid_valid_q;
  logic  out_free;

  // Ready depends only on skid occupancy, breaking the combinational ready path.
  assign arb_ready = ~skid_valid_q;
  assign out_free  = ~out_valid_q | s_axi4_rready;

  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= arb_valid;
        if (arb_valid) out_q <= arb_beat;
      end
    end else if (hs) begin
      skid_q       <= arb_beat;
      skid_valid_q <= 1'b1;
    end
  end

  assign s_axi4_rid    = out_q.id;
  assign s_axi4_rresp  = out_q.resp;
  assign s_axi4_rdata  = out_q.data;
  assign s_axi4_rlast  = out_q.last;
  assign s_axi4_ruser  = out_q.user;
  assign s_axi4_rvalid = out_valid_q;
`else
  assign arb_ready     = s_axi4_rready;
  assign s_axi4_rid    = arb_beat.id;
  assign s_axi4_rresp  = arb_beat.resp;
  assign s_axi4_rdata  = arb_beat.data;
  assign s_axi4_rlast  = arb_beat.last;
  assign s_axi4_ruser  = arb_beat.user;
  assign s_axi4_rvalid = arb_valid;
`endif

  // A locked source must hold its ID while its beat waits for acceptance.
  a_locked_id_stable : assert property (@(posedge axi4_aclk) disable iff (!axi4_arstn)
    (state_q == LOCKED && arb_valid && !arb_ready) |=> $stable(arb_beat.id))
    else $error("locked source changed rid while stalled");

endmodule

// File: tb/tb_axi4_r_burst_arbiter.sv
// Randomized self-checking bench for axi4_r_burst_arbiter against a queue-based arbitration model.
module tb_axi4_r_burst_arbiter;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int UW = 4;
  localparam int N  = 3;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [1:0]    resp;
    logic [DW-1:0] data;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  logic            clk = 1'b0;
  logic            axi4_arstn;
  logic [N*IW-1:0] in_rid;
  logic [N*2-1:0]  in_rresp;
  logic [N*DW-1:0] in_rdata;
  logic [N-1:0]    in_rlast;
  logic [N*UW-1:0] in_ruser;
  logic [N-1:0]    in_rvalid;
  logic [N-1:0]    in_rready;
  logic [IW-1:0]   s_axi4_rid;
  logic [1:0]      s_axi4_rresp;
  logic [DW-1:0]   s_axi4_rdata;
  logic            s_axi4_rlast;
  logic [UW-1:0]   s_axi4_ruser;
  logic            s_axi4_rvalid;
  logic            s_axi4_rready;
  logic            busy_o;

  always #5 clk = ~clk;

  axi4_r_burst_arbiter #(
    .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW), .NUM_IN(N)
  ) dut (
    .axi4_aclk(clk), .axi4_arstn(axi4_arstn),
    .in_rid(in_rid), .in_rresp(in_rresp), .in_rdata(in_rdata), .in_rlast(in_rlast),
    .in_ruser(in_ruser), .in_rvalid(in_rvalid), .in_rready(in_rready),
    .s_axi4_rid(s_axi4_rid), .s_axi4_rresp(s_axi4_rresp), .s_axi4_rdata(s_axi4_rdata),
    .s_axi4_rlast(s_axi4_rlast), .s_axi4_ruser(s_axi4_ruser), .s_axi4_rvalid(s_axi4_rvalid),
    .s_axi4_rready(s_axi4_rready), .busy_o(busy_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Source behaviour: queued beats, a "presenting" flag held until acceptance, and a permission flag.
  beat_t src_q [N][$];
  bit    pres  [N];
  bit    allow [N];

  // Reference model: owner of the current burst (-1 if none) and the source with top priority.
  int    owner    = -1;
  int    next_pri = 0;
  int    acc_src[$];
  beat_t acc_beat[$];

  task automatic add_burst(input int s, input int len, input logic [IW-1:0] id, input logic [DW-1:0] base);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.id   = id;
      b.resp = 2'($urandom_range(3));
      b.data = base + DW'(k);
      b.last = (k == len - 1);
      b.user = UW'($urandom_range(15));
      src_q[s].push_back(b);
    end
  endtask

  function automatic int model_pick();
    if (owner >= 0) return owner;
    for (int k = 0; k < N; k++) begin
      if (pres[(next_pri + k) % N]) return (next_pri + k) % N;
    end
    return -1;
  endfunction

  task automatic drive_inputs();
    beat_t b;
    for (int i = 0; i < N; i++) begin
      if (!pres[i] && allow[i] && src_q[i].size() > 0) pres[i] = 1'b1;
      b = pres[i] ? src_q[i][0] : '0;
      in_rvalid[i]          = pres[i];
      in_rid[i*IW +: IW]    = b.id;
      in_rresp[i*2 +: 2]    = b.resp;
      in_rdata[i*DW +: DW]  = b.data;
      in_rlast[i]           = b.last;
      in_ruser[i*UW +: UW]  = b.user;
    end
  endtask

  task automatic step(input bit ready);
    int         p;
    bit         exp_valid;
    logic [N-1:0] exp_rdy;
    beat_t      b;
    @(negedge clk);
    drive_inputs();
    s_axi4_rready = ready;
    #1;
    p         = model_pick();
    exp_valid = (p >= 0) && pres[p];
    exp_rdy   = (p >= 0 && ready) ? (N'(1) << p) : '0;
    check("rvalid", s_axi4_rvalid, exp_valid);
    check("in_rready", in_rready, exp_rdy);
    check("busy", busy_o, owner >= 0);
    if (exp_valid) begin
      b = src_q[p][0];
      check("payload", {s_axi4_rid, s_axi4_rresp, s_axi4_rdata, s_axi4_rlast, s_axi4_ruser}, b);
      if (ready) begin
        acc_src.push_back(p);
        acc_beat.push_back(b);
        void'(src_q[p].pop_front());
        pres[p] = 1'b0;
        if (b.last) begin
          owner    = -1;
          next_pri = (p + 1) % N;
        end else begin
          owner = p;
        end
      end
    end
  endtask

  task automatic run_until(input int target, input int budget, input bit rand_rdy, input string tag);
    int n = 0;
    while (acc_src.size() < target && n < budget) begin
      step(rand_rdy ? ($urandom_range(3) != 0) : 1'b1);
      n++;
    end
    check(tag, acc_src.size(), target);
  endtask

  task automatic set_allow(input bit a0, input bit a1, input bit a2);
    allow[0] = a0; allow[1] = a1; allow[2] = a2;
  endtask

  int          mark;
  logic [DW-1:0] held_data;

  initial begin
    axi4_arstn    = 1'b0;
    s_axi4_rready = 1'b1;
    set_allow(0, 0, 0);
    for (int i = 0; i < N; i++) pres[i] = 1'b0;
    drive_inputs();
    @(negedge clk);
    @(negedge clk);
    check("reset_rvalid", s_axi4_rvalid, 1'b0);
    check("reset_rready", in_rready, '0);
    check("reset_busy", busy_o, 1'b0);
    axi4_arstn = 1'b1;

    // Source 0 4-beat burst; source 1 joins during beat 2 and must wait for rlast.
    mark = acc_src.size();
    add_burst(0, 4, 4'd3, 32'h10);
    add_burst(1, 2, 4'd5, 32'h20);
    set_allow(1, 0, 0);
    run_until(mark + 1, 4, 0, "t2_first_beat");
    set_allow(1, 1, 0);
    run_until(mark + 6, 12, 0, "t2_done");
    for (int k = 0; k < 6; k++) begin
      check("t2_src", acc_src[mark+k], (k < 4) ? 0 : 1);
      check("t2_data", acc_beat[mark+k].data, (k < 4) ? 32'h10 + k : 32'h20 + k - 4);
    end

    // Single-beat bursts from sources 0 and 1 alternate at full rate.
    set_allow(0, 0, 0);
    mark = acc_src.size();
    for (int k = 0; k < 4; k++) begin
      add_burst(0, 1, 4'd1, 32'h100 + k);
      add_burst(1, 1, 4'd2, 32'h200 + k);
    end
    set_allow(1, 1, 0);
    run_until(mark + 8, 8, 0, "t3_rate");
    for (int k = 0; k < 8; k++) check("t3_alt", acc_src[mark+k], k % 2);

    // Locked source 1 idles for 5 cycles; source 0 must not be served meanwhile.
    set_allow(0, 0, 0);
    mark = acc_src.size();
    add_burst(1, 3, 4'd7, 32'h40);
    add_burst(0, 2, 4'd2, 32'h50);
    set_allow(0, 1, 0);
    run_until(mark + 1, 4, 0, "t4_lock");
    set_allow(1, 0, 0);
    for (int k = 0; k < 5; k++) step(1'b1);
    check("t4_no_preempt", acc_src.size(), mark + 1);
    set_allow(1, 1, 0);
    run_until(mark + 5, 12, 0, "t4_done");
    for (int k = 0; k < 5; k++) check("t4_src", acc_src[mark+k], (k < 3) ? 1 : 0);

    // Downstream stall mid-burst: payload holds, order preserved.
    set_allow(0, 0, 0);
    mark = acc_src.size();
    add_burst(2, 4, 4'd9, 32'h60);
    set_allow(0, 0, 1);
    run_until(mark + 1, 4, 0, "t5_first");
    for (int k = 0; k < 3; k++) begin
      step(1'b0);
      held_data = s_axi4_rdata;
      check("t5_held", held_data, 32'h61);
    end
    run_until(mark + 4, 8, 0, "t5_done");
    for (int k = 0; k < 4; k++) check("t5_order", acc_beat[mark+k].data, 32'h60 + k);

    // Reset during beat 2 of an 8-beat burst from source 1, with the pointer parked at 1.
    set_allow(0, 0, 0);
    mark = acc_src.size();
    add_burst(0, 1, 4'd1, 32'h70);
    set_allow(1, 0, 0);
    run_until(mark + 1, 4, 0, "t6_prime");
    add_burst(1, 8, 4'd4, 32'h80);
    set_allow(0, 1, 0);
    run_until(mark + 2, 4, 0, "t6_beat1");
    @(negedge clk);
    axi4_arstn = 1'b0;
    #1;
    check("t6_busy_reset", busy_o, 1'b0);
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      pres[i] = 1'b0;
    end
    set_allow(0, 0, 0);
    owner    = -1;
    next_pri = 0;
    step(1'b1);
    @(negedge clk);
    axi4_arstn = 1'b1;
    mark = acc_src.size();
    add_burst(0, 1, 4'd1, 32'h90);
    add_burst(1, 1, 4'd2, 32'h91);
    add_burst(2, 1, 4'd3, 32'h92);
    set_allow(1, 1, 1);
    run_until(mark + 1, 2, 0, "t6_after");
    check("t6_winner", acc_src[mark], 0);
    run_until(mark + 3, 6, 0, "t6_drain");

    // Random traffic: random bursts, random source permission, random downstream ready.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() < 4 && $urandom_range(3) == 0)
          add_burst(i, $urandom_range(1, 4), 4'($urandom_range(15)), $urandom);
        allow[i] = ($urandom_range(2) != 0);
      end
      step($urandom_range(3) != 0);
    end
    set_allow(1, 1, 1);
    mark = acc_src.size();
    begin
      int pending = 0;
      for (int i = 0; i < N; i++) pending += src_q[i].size();
      run_until(mark + pending, 200, 0, "rand_drain");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
